// File: rtl/prog_mem_pkg.sv
// prog_mem_pkg
//   Shared constants and types for the program-memory loader slice.
//   DEF_ADDR_W : default width of the memory address bus
//   DEF_DATA_W : default instruction word width (multiple of 8)
//   DEF_DEPTH  : default number of valid memory locations
//   loader_state_e : loader FSM encoding (IDLE, LOAD, WRITE, DONE)
package prog_mem_pkg;

  localparam int DEF_ADDR_W = 11;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } loader_state_e;

endpackage

// File: rtl/prog_mem_loader_word_packer.sv
// word_packer
//   Packs a byte stream MSB-first into a DATA_W-bit word.
//   Ports:
//     clk, rst_n : clock, synchronous active-low reset
//     clr        : restart at byte index 0 (word contents are kept)
//     byte_en    : store s_data this edge
//     s_data     : incoming byte
//     word       : packed word; the first byte of a word ends up in the top byte
//     word_full  : this edge stores the last byte of the word
module word_packer
  import prog_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              byte_en,
  input  logic [7:0]        s_data,
  output logic [DATA_W-1:0] word,
  output logic              word_full
);

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  logic [IDX_W-1:0] byte_idx;

  // Combinational so the FSM can leave LOAD on the same edge that
  // stores the last byte, keeping the 4-bytes-plus-1-write cadence.
  assign word_full = byte_en && (byte_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_idx <= '0;
      word     <= '0;
    end else begin
      if (clr) begin
        byte_idx <= '0;
      end else if (byte_en) begin
        byte_idx <= word_full ? '0 : byte_idx + 1'b1;
      end
      // Shifting left places the first byte of a word in the top byte
      // once all bytes have arrived.
      if (byte_en && !clr) begin
        word <= {word[DATA_W-9:0], s_data};
      end
    end
  end

endmodule

// File: rtl/prog_mem_loader.sv
// prog_mem_loader
//   Writer-side loader for the program memory. Accepts bytes over a
//   valid/ready stream, packs them into words and writes each word at
//   consecutive addresses starting from base_addr. busy holds fetch.
//
//   Handshake: a byte transfers on a rising edge where s_valid && s_ready
//   are both high; s_ready is high only in LOAD and does not depend on
//   s_valid; the source must hold s_data stable while s_valid is high.
//
//   Ports:
//     clk, rst_n    : clock, synchronous active-low reset
//     start         : load request, sampled only in IDLE
//     abort         : cancel load in LOAD/WRITE, next edge back to IDLE
//     base_addr     : first write address (latched on start)
//     word_cnt      : number of words (latched on start)
//     s_valid/s_data/s_ready : byte stream
//     wea/addr/din  : memory write port
//     busy          : loader active (fetch hold)
//     done          : one-cycle pulse on completion
//     err_ovf       : one-cycle pulse, request exceeds DEPTH
//     words_written : words written by current/last load
module prog_mem_loader
  import prog_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_cnt,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              wea,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] din,
  output logic              busy,
  output logic              done,
  output logic              err_ovf,
  output logic [ADDR_W-1:0] words_written
);

  localparam logic [1:0] S_IDLE  = 2'(IDLE);
  localparam logic [1:0] S_LOAD  = 2'(LOAD);
  localparam logic [1:0] S_WRITE = 2'(WRITE);
  localparam logic [1:0] S_DONE  = 2'(DONE);

  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

  logic [1:0]        state;
  logic [ADDR_W-1:0] remaining;
  logic [ADDR_W:0]   end_sum;
  logic              req_zero;
  logic              req_ovf;
  logic              req_accept;
  logic              byte_en;
  logic              packer_clr;
  logic              word_full;

  // One extra bit so base_addr + word_cnt cannot wrap below DEPTH.
  assign end_sum    = {1'b0, base_addr} + {1'b0, word_cnt};
  assign req_zero   = (word_cnt == '0);
  assign req_ovf    = (end_sum > DEPTH_EXT);
  assign req_accept = (state == S_IDLE) && start && !req_zero && !req_ovf;

  assign s_ready = (state == S_LOAD);
  assign wea     = (state == S_WRITE);
  assign busy    = (state != S_IDLE);

  // An abort in LOAD drops the partial word, so the byte seen on that
  // edge is not stored either.
  assign byte_en    = s_valid && s_ready && !abort;
  assign packer_clr = req_accept
                    || (state == S_WRITE)
                    || ((state == S_LOAD) && abort);

  word_packer #(
    .DATA_W (DATA_W)
  ) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (packer_clr),
    .byte_en   (byte_en),
    .s_data    (s_data),
    .word      (din),
    .word_full (word_full)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      addr          <= '0;
      remaining     <= '0;
      words_written <= '0;
      done          <= 1'b0;
      err_ovf       <= 1'b0;
    end else begin
      done    <= 1'b0;
      err_ovf <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (req_zero) begin
              // Empty load completes immediately without leaving IDLE.
              done          <= 1'b1;
              words_written <= '0;
            end else if (req_ovf) begin
              err_ovf <= 1'b1;
            end else begin
              addr          <= base_addr;
              remaining     <= word_cnt;
              words_written <= '0;
              state         <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (word_full) begin
            state <= S_WRITE;
          end
        end
        S_WRITE: begin
          // The write in this cycle always lands, even when aborting.
          addr          <= addr + 1'b1;
          words_written <= words_written + 1'b1;
          remaining     <= remaining - 1'b1;
          if (abort) begin
            state <= S_IDLE;
          end else if (remaining == ADDR_W'(1)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state <= S_LOAD;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_mem_loader.sv
module tb_prog_mem_loader;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;
  localparam int W      = ADDR_W + DATA_W;

  // clock / reset / DUT signals
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] word_cnt = '0;
  logic              s_valid = 1'b0;
  logic [7:0]        s_data = '0;
  logic              s_ready;
  logic              wea;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic              busy;
  logic              done;
  logic              err_ovf;
  logic [ADDR_W-1:0] words_written;

  int total = 0;
  int bad = 0;
  int wea_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int wea_mark;
  int done_mark;

  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  prog_mem_loader dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .base_addr     (base_addr),
    .word_cnt      (word_cnt),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_ready       (s_ready),
    .wea           (wea),
    .addr          (addr),
    .din           (din),
    .busy          (busy),
    .done          (done),
    .err_ovf       (err_ovf),
    .words_written (words_written)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every write is matched against the expected queue
  always @(negedge clk) begin
    logic [W-1:0] exp_w;
    if (rst_n) begin
      if (wea) begin
        wea_cnt++;
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check("write_addr_din", 64'({addr, din}), 64'(exp_w));
        check("ready_low_in_write", 64'(s_ready), 64'd0);
      end
      if (done) done_cnt++;
      if (err_ovf) err_cnt++;
    end
  end

  task automatic start_load(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] c);
    base_addr = b;
    word_cnt  = c;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    int n;
    if (stall) begin
      s_valid = 1'b0;
      tick();
    end
    s_data  = b;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 32) begin
      tick();
      n++;
    end
    check("byte_accept_timeout", 64'(n < 32), 64'd1);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit stall);
    send_byte(w[31:24], stall);
    send_byte(w[23:16], stall);
    send_byte(w[15:8], stall);
    send_byte(w[7:0], stall);
  endtask

  initial begin
    // reset state
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_wea", 64'(wea), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err_ovf", 64'(err_ovf), 64'd0);
    check("rst_addr", 64'(addr), 64'd0);
    check("rst_din", 64'(din), 64'd0);
    check("rst_words_written", 64'(words_written), 64'd0);

    // single word, back-to-back bytes
    start_load(11'd0, 11'd1);
    check("single_busy", 64'(busy), 64'd1);
    check("single_ready", 64'(s_ready), 64'd1);
    exp_q.push_back({11'd0, 32'h12345678});
    send_word(32'h12345678, 1'b0);
    check("single_wea", 64'(wea), 64'd1);
    check("single_addr", 64'(addr), 64'd0);
    check("single_din", 64'(din), 64'h12345678);
    tick();
    check("single_done", 64'(done), 64'd1);
    check("single_busy_done", 64'(busy), 64'd1);
    check("single_wea_off", 64'(wea), 64'd0);
    tick();
    check("single_done_off", 64'(done), 64'd0);
    check("single_idle", 64'(busy), 64'd0);
    check("single_ww", 64'(words_written), 64'd1);
    check("single_final_addr", 64'(addr), 64'd1);

    // reset in the middle of a load
    wea_mark = wea_cnt;
    start_load(11'd2, 11'd2);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_ready", 64'(s_ready), 64'd0);
    check("midrst_wea", 64'(wea), 64'd0);
    check("midrst_ww", 64'(words_written), 64'd0);
    tick();
    tick();
    check("midrst_no_write", 64'(wea_cnt), 64'(wea_mark));

    // three words with stalls
    done_mark = done_cnt;
    start_load(11'd5, 11'd3);
    exp_q.push_back({11'd5, 32'hA1B2C3D4});
    exp_q.push_back({11'd6, 32'h01020304});
    exp_q.push_back({11'd7, 32'hDEADBEEF});
    send_word(32'hA1B2C3D4, 1'b1);
    check("multi_w0_addr", 64'(addr), 64'd5);
    send_word(32'h01020304, 1'b1);
    check("multi_w1_addr", 64'(addr), 64'd6);
    send_word(32'hDEADBEEF, 1'b1);
    check("multi_w2_wea", 64'(wea), 64'd1);
    check("multi_w2_addr", 64'(addr), 64'd7);
    tick();
    check("multi_done", 64'(done), 64'd1);
    tick();
    tick();
    check("multi_done_once", 64'(done_cnt - done_mark), 64'd1);
    check("multi_ww", 64'(words_written), 64'd3);
    check("multi_final_addr", 64'(addr), 64'd8);

    // overflow rejected
    wea_mark = wea_cnt;
    start_load(11'd30, 11'd3);
    check("ovf_pulse", 64'(err_ovf), 64'd1);
    check("ovf_busy", 64'(busy), 64'd0);
    tick();
    check("ovf_pulse_off", 64'(err_ovf), 64'd0);
    check("ovf_no_write", 64'(wea_cnt), 64'(wea_mark));
    check("ovf_count", 64'(err_cnt), 64'd1);

    // exactly fills the memory: accepted
    start_load(11'd29, 11'd3);
    check("edge_ovf_none", 64'(err_ovf), 64'd0);
    check("edge_busy", 64'(busy), 64'd1);
    exp_q.push_back({11'd29, 32'h11111111});
    exp_q.push_back({11'd30, 32'h22222222});
    exp_q.push_back({11'd31, 32'h33333333});
    send_word(32'h11111111, 1'b0);
    send_word(32'h22222222, 1'b0);
    send_word(32'h33333333, 1'b0);
    check("edge_last_addr", 64'(addr), 64'd31);
    tick();
    check("edge_done", 64'(done), 64'd1);
    tick();
    check("edge_ww", 64'(words_written), 64'd3);

    // zero-length load
    wea_mark = wea_cnt;
    start_load(11'd7, 11'd0);
    check("zero_done", 64'(done), 64'd1);
    check("zero_busy", 64'(busy), 64'd0);
    tick();
    check("zero_done_off", 64'(done), 64'd0);
    check("zero_busy_after", 64'(busy), 64'd0);
    check("zero_no_write", 64'(wea_cnt), 64'(wea_mark));

    // abort after six bytes
    wea_mark  = wea_cnt;
    done_mark = done_cnt;
    start_load(11'd10, 11'd4);
    exp_q.push_back({11'd10, 32'hCAFEF00D});
    send_word(32'hCAFEF00D, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_ready", 64'(s_ready), 64'd0);
    tick();
    tick();
    tick();
    check("abort_writes", 64'(wea_cnt - wea_mark), 64'd1);
    check("abort_no_done", 64'(done_cnt - done_mark), 64'd0);
    check("abort_ww", 64'(words_written), 64'd1);
    check("abort_addr", 64'(addr), 64'd11);

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
